spram_port_arbiter: RTL and testbench

- Shares one single-port block RAM (1-cycle registered-address read latency, write on clock edge) between two requesters, e.g. a cache's lookup port (P0) and its refill/writeback port (P1).
- After reset, and on a flush request, a built-in sequencer writes INIT_VALUE to every RAM word to invalidate cache tag/valid arrays.
- Sits between the cache controller and the RAM instance and owns every RAM control pin.

---
 rtl/cache_pkg.sv | 13 +
 rtl/rr_arb2.sv | 32 +++
 rtl/spram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_spram_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the single-port RAM arbiter: FSM encoding and port indices.
package cache_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int unsigned PORT0  = 0;
    localparam int unsigned PORT1  = 1;
    localparam int unsigned NPORTS = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer advances on every grant.
module rr_arb2
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] gnt
);

    // last_p1 set means port 1 was granted most recently, so port 0 wins a tie
    logic last_p1;

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_p1 ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_p1 <= 1'b1;
        end else if (|gnt) begin
            last_p1 <= gnt[PORT1];
        end
    end

endmodule

// File: rtl/spram_port_arbiter.sv
// Shares one single-port RAM between two requesters and clears every word
// after reset or on a flush request.
module spram_port_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 4,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic                  busy,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rd_pend_q;
    logic                    owner_p1_q;
    logic                    run_ok;
    logic [NPORTS-1:0]       arb_req;
    logic [NPORTS-1:0]       arb_gnt;

    // Grants only in RUN, and never in a flush or reset cycle
    assign run_ok  = (state == ST_RUN) && !reset && !flush;
    assign arb_req = {p1_req, p0_req} & {NPORTS{run_ok}};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    assign p0_gnt    = arb_gnt[PORT0];
    assign p1_gnt    = arb_gnt[PORT1];
    assign busy      = (state == ST_CLEAR);
    assign p0_rdata  = ram_rdata;
    assign p1_rdata  = ram_rdata;
    // Reset kills a read response that is already on its way out
    assign p0_rvalid = rd_pend_q && !owner_p1_q && !reset;
    assign p1_rvalid = rd_pend_q &&  owner_p1_q && !reset;

    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (!reset) begin
            case (state)
                ST_CLEAR: begin
                    ram_we    = 1'b1;
                    ram_addr  = clr_cnt;
                    ram_wdata = INIT_VALUE;
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_nxt = ST_CLEAR;
                    end else if (arb_gnt[PORT1]) begin
                        ram_addr  = p1_addr;
                        ram_wdata = p1_wdata;
                        ram_we    = p1_we;
                        ram_re    = !p1_we;
                    end else if (arb_gnt[PORT0]) begin
                        ram_addr  = p0_addr;
                        ram_wdata = p0_wdata;
                        ram_we    = p0_we;
                        ram_re    = !p0_we;
                    end
                end
                default: state_nxt = ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= INIT_VALUE;
            rd_pend_q  <= 1'b0;
            owner_p1_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Counter wraps to zero on the final clear write and rests there in RUN
            clr_cnt    <= (state == ST_CLEAR) ? clr_cnt + ADDR_WIDTH'(1) : '0;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            rd_pend_q  <= ram_re;
            owner_p1_q <= arb_gnt[PORT1];
        end
    end

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Scoreboard bench for spram_port_arbiter with a behavioural single-port RAM.
module tb_spram_port_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          busy;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_re, ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [DW-1:0] mem [16];

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    spram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE('0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .busy(busy),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM: write on edge, registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic expect_read(input int port, input logic [DW-1:0] d);
        exp_t e;
        e.port = port;
        e.data = d;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    // Issue one request at a falling edge and wait (bounded) for its grant
    task automatic access(input int port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                          input int exp_wait);
        int waited = 0;
        bit got    = 0;
        drive(port, 1'b1, we, a, d);
        #1;
        while (!got && waited < 40) begin
            if ((port == 0 && p0_gnt) || (port == 1 && p1_gnt)) got = 1;
            else begin
                @(negedge clk); #1;
                waited++;
            end
        end
        chk($sformatf("p%0d_grant_wait", port), 64'(waited), 64'(exp_wait));
        if (got && !we) expect_read(port, exp_rd);
        @(negedge clk);
        drive(port, 1'b0, we, a, d);
    endtask

    // Starts at a falling edge in the first CLEAR cycle; ends 1 unit into the first RUN cycle
    task automatic check_clear(input int flush_at);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("clr_busy", 64'(busy), 64'd1);
            chk("clr_we", 64'(ram_we), 64'd1);
            chk("clr_re", 64'(ram_re), 64'd0);
            chk("clr_addr", 64'(ram_addr), 64'(i));
            chk("clr_wdata", 64'(ram_wdata), 64'd0);
            chk("clr_no_gnt", 64'({p1_gnt, p0_gnt}), 64'd0);
            flush = (i == flush_at);
            @(negedge clk);
        end
        flush = 1'b0;
        #1;
        chk("run_busy", 64'(busy), 64'd0);
    endtask

    // Response monitor: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        #2;
        if (p0_rvalid || p1_rvalid) begin
            if (p0_rvalid && p1_rvalid) begin
                checks++;
                errors++;
                $display("FAIL dual_rvalid: both rvalid high at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                chk("unexpected_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid_port", p1_rvalid ? 64'd1 : 64'd0, 64'(mon_e.port));
                chk("rdata", 64'(p1_rvalid ? p1_rdata : p0_rdata), 64'(mon_e.data));
                chk("rvalid_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_re", 64'(ram_re), 64'd0);
        chk("rst_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check_clear(-1);
        @(negedge clk);

        // Basic read after clear, write-then-read forwarding through RAM
        access(0, 1'b0, 4'd5, '0, 32'h0, 0);
        access(1, 1'b1, 4'd3, 32'hDEADBEEF, '0, 0);
        access(0, 1'b0, 4'd3, '0, 32'hDEADBEEF, 0);
        access(0, 1'b1, 4'd1, 32'h1111_1111, '0, 0);
        access(1, 1'b1, 4'd2, 32'h2222_2222, '0, 0);

        // Both ports request continuously: alternate starting with P0
        drive(0, 1'b1, 1'b0, 4'd1, '0);
        drive(1, 1'b1, 1'b0, 4'd2, '0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_p0_gnt", 64'(p0_gnt), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_p1_gnt", 64'(p1_gnt), (i % 2 == 1) ? 64'd1 : 64'd0);
            if (p0_gnt) expect_read(0, 32'h1111_1111);
            if (p1_gnt) expect_read(1, 32'h2222_2222);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Flush right after a read grant; pending P1 waits out the clear
        drive(0, 1'b1, 1'b0, 4'd1, '0);
        #1;
        chk("fl_p0_gnt", 64'(p0_gnt), 64'd1);
        if (p0_gnt) expect_read(0, 32'h1111_1111);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 4'd2, '0);
        flush = 1'b1;
        #1;
        chk("fl_no_gnt", 64'({p1_gnt, p0_gnt}), 64'd0);
        chk("fl_busy_low", 64'(busy), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check_clear(-1);
        chk("fl_p1_first_run", 64'(p1_gnt), 64'd1);
        if (p1_gnt) expect_read(1, 32'h0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Flush during CLEAR at count 7 must be ignored
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_clear(7);
        @(negedge clk);

        // Reset right after a P1 read grant suppresses its rvalid
        drive(1, 1'b1, 1'b0, 4'd3, '0);
        #1;
        chk("rs_p1_gnt", 64'(p1_gnt), 64'd1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        #1;
        chk("rs_p1_rvalid", 64'(p1_rvalid), 64'd0);
        @(negedge clk);
        #1;
        chk("rs_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        check_clear(-1);
        @(negedge clk);
        access(0, 1'b0, 4'd3, '0, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
